md5_round_sched: RTL
====================

# md5_round_sched

Sequencing controller for the single-block MD5 datapath. On a qualified trigger (`start` high plus a rising edge of `action`) it latches the 128-bit message and pads it to one 512-bit block. It then drives the datapath through IV load, 64 compression rounds and the final IV add, supplying the round index, F/G/H/I select, rotate amount and padded message word each cycle. It sits between the switch/button front end and the MD5 round datapath and owns the `done`/`digest_valid` status.

## Interface
- `ABORT_EN`, default 1: 1 = `start` low during a run aborts it; 0 = `start` is ignored once running.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  mode switch; the block is armed only while high.
- `action`  in  1  debounced button level; its rising edge triggers a hash.
- `data`  in  128  message; byte 0 = `data[127:120]`.
- `load_iv`  out  1  datapath loads A..D with the MD5 IV.
- `rnd_en`  out  1  datapath executes one round this cycle.
- `rnd`  out  6  round index 0..63.
- `fsel`  out  2  round function: 0=F, 1=G, 2=H, 3=I (`rnd[5:4]`).
- `shamt`  out  5  left-rotate amount.
- `msg_word`  out  32  padded message word M[g] for this round.
- `fin_add`  out  1  datapath adds the IV into A..D and updates the digest register.
- `busy`  out  1  high from the LOAD state through the FINAL state.
- `done`  out  1  one-cycle pulse when the digest is updated.
- `digest_valid`  out  1  digest register holds a completed hash.

## Operation
- States: IDLE → LOAD → ROUND → FINAL → DONE → IDLE.
- `action` is registered every cycle; `trig = start & action & ~action_q`.
- IDLE:
  - on `trig`, latch `data` into `msg_q` and go to LOAD.
  - `action` held high never re-triggers; a new rising edge is required.
- LOAD: `load_iv`=1, clear the round counter, go to ROUND.
- ROUND:
  - `rnd_en`=1 with `rnd` = 0..63, one round per cycle.
  - `rnd`=63 → FINAL.
- FINAL: `fin_add`=1, go to DONE.
- DONE:
  - `done`=1, set `digest_valid`, go to IDLE.
  - a `trig` in this cycle is ignored.
- Word index g:
  - rnd 0–15: g=rnd.
  - rnd 16–31: g=(5·rnd+1) mod 16.
  - rnd 32–47: g=(3·rnd+5) mod 16.
  - rnd 48–63: g=(7·rnd) mod 16.
  - computed modulo 16 in 4 bits (truncation, no divider).
- Rotate amounts per round group, selected by `rnd[1:0]`:
  - rnds 0–15: 7,12,17,22.
  - rnds 16–31: 5,9,14,20.
  - rnds 32–47: 4,11,16,23.
  - rnds 48–63: 6,10,15,21.
- Padding (little-endian words). For g = 0..3, word g = byte-swapped `msg_q[127-32g -: 32]`; g=0 is {byte3,byte2,byte1,byte0}. Remaining words:
  - g=4: 32'h00000080.
  - g=5..13: 0.
  - g=14: 32'h00000080 (length 128 bits).
  - g=15: 0.
- Abort (`ABORT_EN`=1): `start` low in LOAD, ROUND or FINAL → IDLE next cycle.
  - no `fin_add`, no `done`.
  - `digest_valid` unchanged, so the previous digest is retained.
- Strobes `load_iv`, `rnd_en`, `fin_add` and `done` are mutually exclusive.
- When `rnd_en`=0, `rnd`, `fsel`, `shamt` and `msg_word` hold their last values and the datapath ignores them.

## Timing
- Reset (`rst`=0, async): state IDLE.
  - all strobes 0; `busy`=0, `done`=0, `digest_valid`=0.
  - `rnd`, `fsel`, `shamt` and `msg_q` are 0, so `msg_word`=0.
  - `action_q`=0, so a button held through reset release triggers on the first cycle with `start`=1.
- Reset mid-run: immediate return to IDLE, no `done`, `digest_valid` cleared.
- Trigger sampled at edge T:
  - LOAD at T+1.
  - rounds 0..63 at T+2..T+65.
  - FINAL at T+66.
  - DONE (`done`=1) at T+67.
  - ready for a new trigger from T+68.
- Latency is 67 cycles, trigger to `done`.
- All outputs are registered, or decoded from registered state and counter only. No combinational path from inputs to outputs.
- `data` changes after the trigger do not affect the run in progress.

## Structure
- Package `md5_pkg` holds:
  - the state enum;
  - the shift table (16×5-bit);
  - the pad constants (`MD5_PAD_WORD`=32'h80, `MD5_LEN_BITS`=128);
  - the `fsel` encodings.
- One sub-module, `md5_round_lut`: combinational, `rnd` → {`fsel`, g, `shamt`}.
- The padding mux stays in the top level.

## Test plan
- `start`=1, `action` rises, `data`=128'h6162636465666768696a6b6c6d6e6f70 → `load_iv` at T+1; at rnd 0: `msg_word`=32'h64636261, `shamt`=7, `fsel`=0.
- Same run, checked each round → rnd 16: g=1, `shamt`=5; rnd 20: g=5 gives `msg_word`=0; rnd 33: g=8 gives 0; rnd 63: g=9, `shamt`=21, `fsel`=3. Also check `fin_add` at T+66, `done` at T+67, `digest_valid`=1.
- `start`=0 with an `action` edge → stays IDLE; no strobes, `busy`=0.
- `action` held high after a completed run → no second run; release then press again → new run starts.
- `start` dropped at rnd 30 (`ABORT_EN`=1) → IDLE next cycle, no `done`, `digest_valid` keeps its prior value. With `ABORT_EN`=0 the run completes.
- `rst` asserted at rnd 40 → all outputs 0 immediately (async); after release the block waits in IDLE.

Source files
------------

// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared types and constants for the MD5 round sequencer
package md5_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ROUND,
      ST_FINAL,
      ST_DONE
   } state_t;

   localparam logic [1:0] FSEL_F = 2'd0;
   localparam logic [1:0] FSEL_G = 2'd1;
   localparam logic [1:0] FSEL_H = 2'd2;
   localparam logic [1:0] FSEL_I = 2'd3;

   localparam logic [31:0] MD5_PAD_WORD = 32'h0000_0080;
   localparam logic [31:0] MD5_LEN_BITS = 32'd128;

   // Indexed by {rnd[5:4], rnd[1:0]}; entry 0 is the rightmost element.
   localparam logic [15:0][4:0] MD5_SHIFT = {
      5'd21, 5'd15, 5'd10, 5'd6,
      5'd23, 5'd16, 5'd11, 5'd4,
      5'd20, 5'd14, 5'd9,  5'd5,
      5'd22, 5'd17, 5'd12, 5'd7
   };

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/md5_round_sched_if.sv
// rtl/md5_round_sched_if.sv - front-end trigger and datapath control bundle
interface md5_round_sched_if;
   logic         start;
   logic         action;
   logic [127:0] data;
   logic         load_iv;
   logic         rnd_en;
   logic [5:0]   rnd;
   logic [1:0]   fsel;
   logic [4:0]   shamt;
   logic [31:0]  msg_word;
   logic         fin_add;
   logic         busy;
   logic         done;
   logic         digest_valid;

   modport master (
      output start, action, data,
      input  load_iv, rnd_en, rnd, fsel, shamt, msg_word,
      input  fin_add, busy, done, digest_valid
   );

   modport slave (
      input  start, action, data,
      output load_iv, rnd_en, rnd, fsel, shamt, msg_word,
      output fin_add, busy, done, digest_valid
   );
endinterface

// File: rtl/md5_round_lut.sv
// rtl/md5_round_lut.sv - round index to function select, word index and rotate amount
module md5_round_lut
   import md5_pkg::*;
(
   input  logic [5:0] rnd,
   output logic [1:0] fsel,
   output logic [3:0] g,
   output logic [4:0] shamt
);

   logic [3:0] r;
   assign r = rnd[3:0];

   // 4-bit arithmetic wraps, which is exactly the mod-16 the word index needs.
   always_comb begin
      fsel = FSEL_F;
      g    = r;
      case (rnd[5:4])
         2'd0: begin fsel = FSEL_F; g = r; end
         2'd1: begin fsel = FSEL_G; g = r * 4'd5 + 4'd1; end
         2'd2: begin fsel = FSEL_H; g = r * 4'd3 + 4'd5; end
         default: begin fsel = FSEL_I; g = r * 4'd7; end
      endcase
   end

   assign shamt = MD5_SHIFT[{rnd[5:4], rnd[1:0]}];

endmodule

// File: rtl/md5_round_sched.sv
// rtl/md5_round_sched.sv - single-block MD5 sequencer: trigger, padding, round control
module md5_round_sched
   import md5_pkg::*;
#(
   parameter bit ABORT_EN = 1'b1
) (
   input logic             clk,
   input logic             rst,
   md5_round_sched_if.slave bus
);

   state_t       state_q, state_d;
   logic         action_q;
   logic [127:0] msg_q;
   logic [5:0]   rnd_q;
   logic         ran_q;
   logic         digest_valid_q;
   logic         trig, abort;
   logic [1:0]   lut_fsel;
   logic [3:0]   lut_g;
   logic [4:0]   lut_shamt;
   logic [31:0]  word;
   logic         load_iv, rnd_en, fin_add, done_p, busy;

   assign trig  = bus.start & bus.action & ~action_q;
   assign abort = ABORT_EN & ~bus.start;

   always_comb begin
      state_d = state_q;
      load_iv = 1'b0;
      rnd_en  = 1'b0;
      fin_add = 1'b0;
      done_p  = 1'b0;
      busy    = 1'b0;
      case (state_q)
         ST_IDLE: if (trig) state_d = ST_LOAD;
         ST_LOAD: begin
            load_iv = 1'b1;
            busy    = 1'b1;
            state_d = abort ? ST_IDLE : ST_ROUND;
         end
         ST_ROUND: begin
            rnd_en = 1'b1;
            busy   = 1'b1;
            if (abort) state_d = ST_IDLE;
            else if (rnd_q == 6'd63) state_d = ST_FINAL;
         end
         ST_FINAL: begin
            fin_add = 1'b1;
            busy    = 1'b1;
            state_d = abort ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            done_p  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         action_q       <= 1'b0;
         msg_q          <= '0;
         rnd_q          <= '0;
         ran_q          <= 1'b0;
         digest_valid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         action_q <= bus.action;
         if (state_q == ST_IDLE && trig) msg_q <= bus.data;
         if (state_q == ST_LOAD) begin
            rnd_q <= '0;
            ran_q <= 1'b1;
         end else if (state_q == ST_ROUND && state_d == ST_ROUND) begin
            rnd_q <= rnd_q + 6'd1;
         end
         if (state_q == ST_DONE) digest_valid_q <= 1'b1;
      end
   end

   md5_round_lut u_lut (
      .rnd   (rnd_q),
      .fsel  (lut_fsel),
      .g     (lut_g),
      .shamt (lut_shamt)
   );

   // Message words 0..3 come from the latched block, the rest is fixed 128-bit padding.
   always_comb begin
      word = '0;
      case (lut_g)
         4'd0:    word = bswap32(msg_q[127:96]);
         4'd1:    word = bswap32(msg_q[95:64]);
         4'd2:    word = bswap32(msg_q[63:32]);
         4'd3:    word = bswap32(msg_q[31:0]);
         4'd4:    word = MD5_PAD_WORD;
         4'd14:   word = MD5_LEN_BITS;
         default: word = '0;
      endcase
   end

   assign bus.load_iv      = load_iv;
   assign bus.rnd_en       = rnd_en;
   assign bus.rnd          = rnd_q;
   assign bus.fsel         = lut_fsel;
   assign bus.shamt        = ran_q ? lut_shamt : 5'd0;
   assign bus.msg_word     = word;
   assign bus.fin_add      = fin_add;
   assign bus.busy         = busy;
   assign bus.done         = done_p;
   assign bus.digest_valid = digest_valid_q;

endmodule
